// File: rtl/prio_encoder_pipe.sv
// Registered N-to-log2(N) request encoder with valid/ready handshake on both sides.
// MODE 0 grants the lowest set bit; MODE 1 grants round-robin from a rotating pointer.
module prio_encoder_pipe #(
  parameter int N     = 8,
  parameter int W     = $clog2(N),
  parameter int MODE  = 0,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld,
  input  logic [N-1:0]     in_req,
  output logic             in_rdy,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [W-1:0]     out_idx,
  output logic             out_multi,
  output logic             out_none,
  output logic [CNT_W-1:0] multi_cnt
);

  logic [W-1:0] ptr_r;
  logic [W-1:0] win_s;
  logic [W-1:0] next_ptr_s;
  logic [W-1:0] scan_idx_s;
  logic         found_s;
  logic         accept_s;
  logic         none_s;
  logic         multi_s;
  int           scan_pos_s;

  assign in_rdy   = !out_vld || out_rdy;
  assign accept_s = in_vld && in_rdy;
  assign none_s   = (in_req == {N{1'b0}});
  // Clearing the lowest set bit leaves something behind only when two or more bits are set.
  assign multi_s  = |(in_req & (in_req - N'(1)));

  // Winner search: scan N positions starting at the pointer (MODE 1) or at 0 (MODE 0).
  always_comb begin
    win_s      = {W{1'b0}};
    found_s    = 1'b0;
    scan_pos_s = 0;
    scan_idx_s = {W{1'b0}};
    for (int k = 0; k < N; k++) begin
      scan_pos_s = (MODE == 1) ? int'(ptr_r) + k : k;
      scan_pos_s = (scan_pos_s >= N) ? scan_pos_s - N : scan_pos_s;
      scan_idx_s = W'(scan_pos_s);
      win_s      = (!found_s && in_req[scan_idx_s]) ? scan_idx_s : win_s;
      found_s    = found_s || in_req[scan_idx_s];
    end
  end

  // Pointer advance: the position just after the winner, wrapping at N-1.
  always_comb begin
    if (int'(win_s) == N - 1) begin
      next_ptr_s = {W{1'b0}};
    end else begin
      next_ptr_s = win_s + W'(1);
    end
  end

  // Result stage: load on accept, retire when consumed, hold under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld   <= 1'b0;
      out_idx   <= {W{1'b0}};
      out_multi <= 1'b0;
      out_none  <= 1'b0;
    end else if (accept_s) begin
      out_vld   <= 1'b1;
      out_idx   <= none_s ? {W{1'b0}} : win_s;
      out_multi <= multi_s;
      out_none  <= none_s;
    end else if (out_rdy) begin
      out_vld   <= 1'b0;
    end
  end

  // Round-robin pointer: moves only on a granted (nonzero) accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= {W{1'b0}};
    end else if ((MODE == 1) && accept_s && !none_s) begin
      ptr_r <= next_ptr_s;
    end
  end

  // Saturating count of accepted multi-hot requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      multi_cnt <= {CNT_W{1'b0}};
    end else if (accept_s && multi_s && (multi_cnt != {CNT_W{1'b1}})) begin
      multi_cnt <= multi_cnt + CNT_W'(1);
    end
  end

endmodule
